passcode_lock_ctrl: RTL and testbench
=====================================

Name: passcode_lock_ctrl

Overview:
Parametrised keypad passcode lock controller, successor to the fixed 4/8-digit lock datapath. It takes debounced BCD digit strobes, accumulates a DIGITS-long entry and compares it against a stored code. It tracks failed attempts, raises a latched alarm after MAX_ATTEMPTS failures and holds the door unlocked for a timed window. While unlocked it can reprogram the code. All state is synchronous to one clock; there are no derived or rippled clocks.

Parameters:
DIGITS, 4, code length in BCD digits; legal range 1..8.
MAX_ATTEMPTS, 3, consecutive failed entries that trigger the alarm; legal range 1..15.
UNLOCK_CYCLES, 1000, clk cycles the unlocked output is held; must be >= 1.
RESET_CODE, 16'h1234, stored code after reset, 4*DIGITS bits; the most significant nibble is the first digit entered.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
key_valid  in  1  one-cycle strobe; key_code is valid.
key_code  in  4  BCD digit; values 10..15 are ignored.
enter  in  1  one-cycle strobe; submit the current entry.
clear  in  1  one-cycle strobe; discard the current entry.
prog_en  in  1  level; while unlocked, enter stores the entry as the new code.
alarm_clr  in  1  one-cycle strobe; acknowledge and clear the alarm.
unlocked  out  1  high in the UNLOCKED state.
alarm  out  1  high in the ALARM state.
digit_count  out  4  number of digits in the current entry, 0..DIGITS.
attempts  out  4  consecutive failed entries, 0..MAX_ATTEMPTS.
code_updated  out  1  one-cycle pulse when a new code is stored.

Behaviour:
- Reset (rst=0, asynchronous): state=LOCKED; code=RESET_CODE; entry=0; digit_count=0; attempts=0; timer=0; unlocked=0; alarm=0; code_updated=0.
- States: LOCKED, UNLOCKED, ALARM. All outputs are registered.
- Entry register, 4*DIGITS bits, shared by LOCKED and UNLOCKED:
  - key_valid with key_code<=9 and digit_count<DIGITS: entry <= {entry[4*DIGITS-5:0], key_code}; digit_count++.
  - Digit key when digit_count==DIGITS: ignored, no wrap. key_code>9: ignored.
- Same-cycle priority: clear > enter > key_valid. The lower-priority strobes are dropped that cycle.
- clear: entry<=0, digit_count<=0. State and attempts are unchanged.
- Any accepted enter clears the entry and digit_count on the same edge.
- LOCKED, on enter:
  - digit_count==DIGITS and entry==code: next state UNLOCKED; attempts<=0; timer<=UNLOCK_CYCLES-1; unlocked=1 from the following cycle (1-cycle latency).
  - Otherwise, including a short entry: fail. If attempts+1==MAX_ATTEMPTS, go to ALARM with attempts=MAX_ATTEMPTS; else attempts++.
- UNLOCKED:
  - timer decrements each cycle; at timer==0 with no enter, go to LOCKED. unlocked is high for exactly UNLOCK_CYCLES cycles.
  - enter with prog_en=1 and digit_count==DIGITS: code<=entry; code_updated=1 for one cycle; timer reloads to UNLOCK_CYCLES-1; stay UNLOCKED.
  - enter with prog_en=1 and a short entry: entry cleared; no code change; timer keeps running.
  - enter with prog_en=0: relock immediately (next state LOCKED); attempts unchanged at 0.
  - enter takes precedence over timer expiry in the same cycle.
- ALARM:
  - alarm=1. key_valid, enter and clear are ignored; the entry is held at 0.
  - alarm_clr: next state LOCKED; attempts<=0; alarm drops 1 cycle later.
  - alarm_clr in any other state is ignored.
- Asserting rst in any state, mid-entry or mid-timer, returns everything to the reset values. The stored code also reverts to RESET_CODE.
- Comparison is a full 4*DIGITS-bit equality. The timer width is clog2(UNLOCK_CYCLES+1).

Test Plan:
1. Reset; keys 1,2,3,4; enter -> unlocked=1 on the cycle after enter, held exactly UNLOCK_CYCLES (1000) cycles, then 0; attempts=0.
2. Keys 1,2,3,5 + enter three times (MAX_ATTEMPTS=3) -> attempts 1,2, then alarm=1; keys 1,2,3,4 + enter are ignored; alarm_clr -> alarm=0, attempts=0, and code 1234 unlocks again.
3. Unlock with 1234; prog_en=1; keys 9,8,7,6; enter -> code_updated one-cycle pulse, timer reloaded; after relock, 1234+enter fails (attempts=1) and 9876+enter unlocks.
4. Keys 1,2,3,4,5 -> digit_count saturates at 4 and entry stays 1234; key_code=12 ignored; clear and enter in the same cycle -> entry cleared, no attempt counted.
5. Short entry 1,2 + enter in LOCKED -> attempts=1; enter with prog_en=0 while UNLOCKED -> LOCKED next cycle.
6. rst pulsed low mid-entry (2 digits) and during UNLOCKED after reprogramming -> all outputs 0, digit_count=0, and the code reverts to 1234.

Source files
------------

// File: rtl/passcode_lock_ctrl.sv
// Keypad passcode lock: accumulates a BCD entry, compares it against a stored
// code, counts failures into a latched alarm and holds the door open for a timed window.
module passcode_lock_ctrl #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned MAX_ATTEMPTS  = 3,
  parameter int unsigned UNLOCK_CYCLES = 1000,
  parameter logic [4*DIGITS-1:0] RESET_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       enter,
  input  logic       clear,
  input  logic       prog_en,
  input  logic       alarm_clr,
  output logic       unlocked,
  output logic       alarm,
  output logic [3:0] digit_count,
  output logic [3:0] attempts,
  output logic       code_updated
);

  localparam int unsigned EW = 4 * DIGITS;
  localparam int unsigned TW = $clog2(UNLOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    ALARM    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   code_q, code_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [3:0]      count_q, count_d;
  logic [3:0]      attempts_q, attempts_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            updated_q, updated_d;
  logic            unlocked_q, alarm_q;

  logic entry_full;
  logic key_ok;

  assign entry_full = (count_q == 4'(DIGITS));
  assign key_ok     = key_valid && (key_code <= 4'd9) && !entry_full;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    entry_d    = entry_q;
    count_d    = count_q;
    attempts_d = attempts_q;
    timer_d    = timer_q;
    updated_d  = 1'b0;

    // Entry register is shared by LOCKED and UNLOCKED; priority clear > enter > key.
    if (state_q != ALARM) begin
      if (clear || enter) begin
        entry_d = '0;
        count_d = '0;
      end else if (key_ok) begin
        entry_d = (entry_q << 4) | EW'(key_code);
        count_d = count_q + 4'd1;
      end
    end

    unique case (state_q)
      LOCKED: begin
        if (enter && !clear) begin
          if (entry_full && (entry_q == code_q)) begin
            state_d    = UNLOCKED;
            attempts_d = '0;
            timer_d    = TW'(UNLOCK_CYCLES - 1);
          end else if (attempts_q + 4'd1 == 4'(MAX_ATTEMPTS)) begin
            state_d    = ALARM;
            attempts_d = 4'(MAX_ATTEMPTS);
          end else begin
            attempts_d = attempts_q + 4'd1;
          end
        end
      end
      UNLOCKED: begin
        if (enter && !clear && !prog_en) begin
          state_d = LOCKED;
          timer_d = '0;
        end else if (enter && !clear && entry_full) begin
          code_d    = entry_q;
          updated_d = 1'b1;
          timer_d   = TW'(UNLOCK_CYCLES - 1);
        end else if (timer_q == '0) begin
          state_d = LOCKED;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ALARM: begin
        entry_d = '0;
        count_d = '0;
        if (alarm_clr) begin
          state_d    = LOCKED;
          attempts_d = '0;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOCKED;
      code_q     <= RESET_CODE;
      entry_q    <= '0;
      count_q    <= '0;
      attempts_q <= '0;
      timer_q    <= '0;
      updated_q  <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      attempts_q <= attempts_d;
      timer_q    <= timer_d;
      updated_q  <= updated_d;
      unlocked_q <= (state_d == UNLOCKED);
      alarm_q    <= (state_d == ALARM);
    end
  end

  assign unlocked     = unlocked_q;
  assign alarm        = alarm_q;
  assign digit_count  = count_q;
  assign attempts     = attempts_q;
  assign code_updated = updated_q;

endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Directed bench for passcode_lock_ctrl with default parameters
// (4 digits, 3 attempts, 1000-cycle unlock window, reset code 1234).
module tb_passcode_lock_ctrl;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       enter;
  logic       clear;
  logic       prog_en;
  logic       alarm_clr;
  logic       unlocked;
  logic       alarm;
  logic [3:0] digit_count;
  logic [3:0] attempts;
  logic       code_updated;

  int tests_run;
  int tests_failed;

  passcode_lock_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .enter        (enter),
    .clear        (clear),
    .prog_en      (prog_en),
    .alarm_clr    (alarm_clr),
    .unlocked     (unlocked),
    .alarm        (alarm),
    .digit_count  (digit_count),
    .attempts     (attempts),
    .code_updated (code_updated)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic press_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    press_key(c[15:12]);
    press_key(c[11:8]);
    press_key(c[7:4]);
    press_key(c[3:0]);
    press_enter();
  endtask

  // Counts consecutive unlocked samples, starting from the current one.
  task automatic count_unlocked(output int n);
    n = 0;
    while (unlocked === 1'b1 && n < 1100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({unlocked, alarm, digit_count, attempts, code_updated} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 0", {unlocked, alarm, digit_count, attempts, code_updated});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unlock_window();
    int n;
    enter_code(16'h1234);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL unlock_latency: unlocked=%b want 1", unlocked);
    end
    count_unlocked(n);
    tests_run++;
    if (n != 1000) begin
      tests_failed++;
      $display("FAIL unlock_window: held %0d cycles want 1000", n);
    end
    tests_run++;
    if (unlocked !== 1'b0 || attempts !== 4'd0) begin
      tests_failed++;
      $display("FAIL relock_after_window: unlocked=%b attempts=%0d want 0/0", unlocked, attempts);
    end
  endtask

  task automatic test_alarm();
    enter_code(16'h1235);
    tests_run++;
    if (attempts !== 4'd1 || alarm !== 1'b0) begin
      tests_failed++;
      $display("FAIL fail_1: attempts=%0d alarm=%b want 1/0", attempts, alarm);
    end
    enter_code(16'h1235);
    tests_run++;
    if (attempts !== 4'd2 || alarm !== 1'b0) begin
      tests_failed++;
      $display("FAIL fail_2: attempts=%0d alarm=%b want 2/0", attempts, alarm);
    end
    enter_code(16'h1235);
    tests_run++;
    if (attempts !== 4'd3 || alarm !== 1'b1) begin
      tests_failed++;
      $display("FAIL alarm_set: attempts=%0d alarm=%b want 3/1", attempts, alarm);
    end
    enter_code(16'h1234);
    tests_run++;
    if (alarm !== 1'b1 || unlocked !== 1'b0 || digit_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL alarm_ignores_keys: alarm=%b unlocked=%b count=%0d want 1/0/0", alarm, unlocked, digit_count);
    end
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    tests_run++;
    if (alarm !== 1'b0 || attempts !== 4'd0) begin
      tests_failed++;
      $display("FAIL alarm_clr: alarm=%b attempts=%0d want 0/0", alarm, attempts);
    end
    enter_code(16'h1234);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL unlock_after_alarm: unlocked=%b want 1", unlocked);
    end
    prog_en = 1'b0;
    press_enter();
    tests_run++;
    if (unlocked !== 1'b0) begin
      tests_failed++;
      $display("FAIL relock_after_alarm: unlocked=%b want 0", unlocked);
    end
  endtask

  task automatic test_saturate_clear();
    press_key(4'd12);
    tests_run++;
    if (digit_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL non_bcd_ignored: count=%0d want 0", digit_count);
    end
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd3);
    press_key(4'd4);
    press_key(4'd5);
    tests_run++;
    if (digit_count !== 4'd4) begin
      tests_failed++;
      $display("FAIL count_saturate: count=%0d want 4", digit_count);
    end
    press_key(4'd12);
    press_enter();
    tests_run++;
    if (unlocked !== 1'b1 || digit_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL entry_kept_1234: unlocked=%b count=%0d want 1/0", unlocked, digit_count);
    end
    press_enter();
    press_key(4'd1);
    press_key(4'd2);
    clear = 1'b1;
    enter = 1'b1;
    tick();
    clear = 1'b0;
    enter = 1'b0;
    tests_run++;
    if (digit_count !== 4'd0 || attempts !== 4'd0 || unlocked !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_over_enter: count=%0d attempts=%0d unlocked=%b want 0/0/0", digit_count, attempts, unlocked);
    end
  endtask

  task automatic test_short_and_relock();
    press_key(4'd1);
    press_key(4'd2);
    press_enter();
    tests_run++;
    if (attempts !== 4'd1 || digit_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL short_entry: attempts=%0d count=%0d want 1/0", attempts, digit_count);
    end
    enter_code(16'h1234);
    tests_run++;
    if (unlocked !== 1'b1 || attempts !== 4'd0) begin
      tests_failed++;
      $display("FAIL unlock_resets_attempts: unlocked=%b attempts=%0d want 1/0", unlocked, attempts);
    end
    tick();
    prog_en = 1'b0;
    press_enter();
    tests_run++;
    if (unlocked !== 1'b0 || attempts !== 4'd0) begin
      tests_failed++;
      $display("FAIL enter_relock: unlocked=%b attempts=%0d want 0/0", unlocked, attempts);
    end
  endtask

  task automatic test_reprogram();
    int n;
    enter_code(16'h1234);
    prog_en = 1'b1;
    repeat (20) tick();
    enter_code(16'h9876);
    tests_run++;
    if (code_updated !== 1'b1 || unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL code_updated_pulse: pulse=%b unlocked=%b want 1/1", code_updated, unlocked);
    end
    prog_en = 1'b0;
    count_unlocked(n);
    tests_run++;
    if (n != 1000) begin
      tests_failed++;
      $display("FAIL timer_reload: held %0d cycles after reprogram want 1000", n);
    end
    enter_code(16'h1234);
    tests_run++;
    if (unlocked !== 1'b0 || attempts !== 4'd1) begin
      tests_failed++;
      $display("FAIL old_code_rejected: unlocked=%b attempts=%0d want 0/1", unlocked, attempts);
    end
    enter_code(16'h9876);
    tests_run++;
    if (unlocked !== 1'b1 || attempts !== 4'd0 || code_updated !== 1'b0) begin
      tests_failed++;
      $display("FAIL new_code_accepted: unlocked=%b attempts=%0d pulse=%b want 1/0/0", unlocked, attempts, code_updated);
    end
    press_enter();
  endtask

  task automatic test_reset_midway();
    press_key(4'd1);
    press_key(4'd2);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (digit_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset_entry: count=%0d want 0", digit_count);
    end
    tick();
    rst = 1'b1;
    tick();
    enter_code(16'h1234);
    prog_en = 1'b1;
    enter_code(16'h5555);
    prog_en = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({unlocked, alarm, digit_count, attempts, code_updated} !== 11'd0) begin
      tests_failed++;
      $display("FAIL async_reset_unlocked: got %b want 0", {unlocked, alarm, digit_count, attempts, code_updated});
    end
    tick();
    rst = 1'b1;
    tick();
    enter_code(16'h1234);
    tests_run++;
    if (unlocked !== 1'b1 || attempts !== 4'd0) begin
      tests_failed++;
      $display("FAIL code_reverts: unlocked=%b attempts=%0d want 1/0", unlocked, attempts);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    enter     = 1'b0;
    clear     = 1'b0;
    prog_en   = 1'b0;
    alarm_clr = 1'b0;
    #1;
    test_reset();
    test_unlock_window();
    test_alarm();
    test_saturate_clear();
    test_short_and_relock();
    test_reprogram();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
